// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the CPU boot loader: FSM state encoding,
// default mailbox window and the well-known mailbox offsets.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_GAP,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam logic [31:0] DEF_MMIO_BASE = 32'h0200_0000;
    localparam logic [31:0] DEF_MMIO_SIZE = 32'h0000_0100;

    // Mailbox offsets relative to the window base, as used by t1c_riscv_cpu firmware.
    localparam logic [31:0] START_POINT = 32'h0000_0000;
    localparam logic [31:0] END_POINT   = 32'h0000_0004;
    localparam logic [31:0] NODE_POINT  = 32'h0000_0008;
    localparam logic [31:0] CPU_DONE    = 32'h0000_000C;

endpackage

// File: rtl/boot_addr_check.sv
// Combinational legality check for a preload word: aligned, inside the
// mailbox window, and the session word counter still has headroom.
module boot_addr_check
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter logic [31:0] MMIO_SIZE = DEF_MMIO_SIZE,
    parameter int unsigned CNT_W     = 8
) (
    input  logic [31:0]      addr,
    input  logic [CNT_W-1:0] word_cnt,
    output logic             ok
);

    logic [31:0] offset;
    logic        aligned;
    logic        in_window;
    logic        cnt_room;

    // Offset compare avoids overflow when the window touches the top of the address space.
    assign offset    = addr - MMIO_BASE;
    assign aligned   = (addr[1:0] == 2'b00);
    assign in_window = (addr >= MMIO_BASE) && (offset < MMIO_SIZE);
    assign cnt_room  = (word_cnt != {CNT_W{1'b1}});
    assign ok        = aligned && in_window && cnt_room;

endmodule

// File: rtl/cpu_boot_loader.sv
// Preload sequencer for t1c_riscv_cpu: streams (addr, data) words into the CPU's
// external write port, then releases cpu_reset. Define BOOT_LOADER_CKSUM_EN for a cksum output.
module cpu_boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE   = DEF_MMIO_BASE,
    parameter logic [31:0] MMIO_SIZE   = DEF_MMIO_SIZE,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned RELEASE_DLY = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [31:0]      ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             Ext_MemWrite,
    output logic [31:0]      Ext_WriteData,
    output logic [31:0]      Ext_DataAdr,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] word_cnt
`ifdef BOOT_LOADER_CKSUM_EN
    ,
    output logic [31:0]      cksum
`endif
);

    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);
    localparam bit         REL_SKIP = (RELEASE_DLY == 0);
    localparam logic [3:0] REL_INIT = REL_SKIP ? 4'd0 : 4'(RELEASE_DLY - 1);

    state_t     state;
    logic       last_q;
    logic [3:0] gap_cnt;
    logic [3:0] rel_cnt;
    logic       word_ok;

    boot_addr_check #(
        .MMIO_BASE (MMIO_BASE),
        .MMIO_SIZE (MMIO_SIZE),
        .CNT_W     (CNT_W)
    ) u_addr_check (
        .addr     (ld_addr),
        .word_cnt (word_cnt),
        .ok       (word_ok)
    );

    assign ld_ready = (state == ST_LOAD);
    assign busy     = (state inside {ST_LOAD, ST_WRITE, ST_GAP, ST_RELEASE});
    assign done     = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cpu_reset     <= 1'b1;
            Ext_MemWrite  <= 1'b0;
            Ext_WriteData <= '0;
            Ext_DataAdr   <= '0;
            err           <= 1'b0;
            word_cnt      <= '0;
            last_q        <= 1'b0;
            gap_cnt       <= '0;
            rel_cnt       <= '0;
`ifdef BOOT_LOADER_CKSUM_EN
            cksum         <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        word_cnt <= '0;
                        err      <= 1'b0;
`ifdef BOOT_LOADER_CKSUM_EN
                        cksum    <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        last_q <= ld_last;
                        if (word_ok) begin
                            // Write port is loaded here so the pulse lands in the very next cycle.
                            state         <= ST_WRITE;
                            Ext_MemWrite  <= 1'b1;
                            Ext_DataAdr   <= ld_addr;
                            Ext_WriteData <= ld_data;
                        end else begin
                            err <= 1'b1;
                            if (ld_last) begin
                                if (REL_SKIP) begin
                                    state     <= ST_RUN;
                                    cpu_reset <= 1'b0;
                                end else begin
                                    state   <= ST_RELEASE;
                                    rel_cnt <= REL_INIT;
                                end
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    Ext_MemWrite  <= 1'b0;
                    Ext_DataAdr   <= '0;
                    Ext_WriteData <= '0;
                    word_cnt      <= word_cnt + 1'b1;
                    gap_cnt       <= GAP_INIT;
                    state         <= ST_GAP;
`ifdef BOOT_LOADER_CKSUM_EN
                    cksum         <= cksum + (Ext_DataAdr ^ Ext_WriteData);
`endif
                end
                ST_GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (!last_q) begin
                        state <= ST_LOAD;
                    end else if (REL_SKIP) begin
                        state     <= ST_RUN;
                        cpu_reset <= 1'b0;
                    end else begin
                        state   <= ST_RELEASE;
                        rel_cnt <= REL_INIT;
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt != 4'd0) begin
                        rel_cnt <= rel_cnt - 1'b1;
                    end else begin
                        state     <= ST_RUN;
                        cpu_reset <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Reboot: re-assert the CPU reset and open a fresh session.
                    if (start) begin
                        state     <= ST_LOAD;
                        cpu_reset <= 1'b1;
                        word_cnt  <= '0;
                        err       <= 1'b0;
`ifdef BOOT_LOADER_CKSUM_EN
                        cksum     <= '0;
`endif
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule
